// File: rtl/wb_dest_queue_if.sv
// wb_dest_queue_if: decode-side bus of the write-back destination queue.
interface wb_dest_queue_if #(
  parameter int REG_W = 5,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [1:0]       sel;
  logic             push;
  logic             pop;
  logic             flush;
  logic [REG_W-1:0] lookup_reg;
  logic             lookup_hit;
  logic [REG_W-1:0] dest_out;
  logic             dest_valid;
  logic             full;
  logic             empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output rt, rd, sel, push, pop, flush, lookup_reg,
    input  lookup_hit, dest_out, dest_valid, full, empty, count, overflow, underflow
  );
  modport slave (
    input  rt, rd, sel, push, pop, flush, lookup_reg,
    output lookup_hit, dest_out, dest_valid, full, empty, count, overflow, underflow
  );
endinterface

// File: rtl/wb_dest_queue.sv
// wb_dest_queue: selects the write-back destination and holds it in a FIFO until the result retires.
module wb_dest_queue #(
  parameter int REG_W  = 5,
  parameter int DEPTH  = 4,
  parameter int SP_IDX = 29,
  parameter int RA_IDX = 31
) (
  input logic            clk,
  input logic            reset,
  wb_dest_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [REG_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wp, rp;
  logic [CW-1:0]    cnt;
  logic             ovf, udf, is_full, is_empty, wr, rd_ok, hit;
  logic [REG_W-1:0] sel_idx;
  assign sel_idx  = bus.sel[1] ? (bus.sel[0] ? REG_W'(RA_IDX) : REG_W'(SP_IDX))
                               : (bus.sel[0] ? bus.rd : bus.rt);
  assign is_full  = cnt == CW'(DEPTH);
  assign is_empty = cnt == '0;
  assign rd_ok    = bus.pop & ~is_empty;
  // a pop frees the slot, so a push into a full queue still lands when paired with one
  assign wr       = bus.push & (~is_full | rd_ok);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      vld <= '0;
    end else begin
      if (rd_ok) begin
        vld[rp] <= 1'b0;
        rp      <= rp + PW'(1);
      end
      // when full, wp == rp: the later set keeps the replacing entry valid
      if (wr) begin
        mem[wp] <= sel_idx;
        vld[wp] <= 1'b1;
        wp      <= wp + PW'(1);
      end
      cnt <= cnt + CW'(wr) - CW'(rd_ok);
      if (bus.push & is_full & ~bus.pop) ovf <= 1'b1;
      if (bus.pop & is_empty & ~bus.push) udf <= 1'b1;
    end
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit = hit | (vld[i] & (mem[i] == bus.lookup_reg));
  end
  assign bus.lookup_hit = hit & (|bus.lookup_reg);
  assign bus.dest_out   = is_empty ? '0 : mem[rp];
  assign bus.dest_valid = ~is_empty;
  assign bus.full       = is_full;
  assign bus.empty      = is_empty;
  assign bus.count      = cnt;
  assign bus.overflow   = ovf;
  assign bus.underflow  = udf;
endmodule

// File: tb/tb_wb_dest_queue.sv
// tb_wb_dest_queue: directed plus randomized checks against a queue-based reference model.
module tb_wb_dest_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   q[$];
  bit   m_ov, m_ud;
  wb_dest_queue_if #(.REG_W(5), .DEPTH(DEPTH)) bus ();
  wb_dest_queue #(.REG_W(5), .DEPTH(DEPTH), .SP_IDX(29), .RA_IDX(31)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit m_hit(input int lr);
    if (lr == 0) return 1'b0;
    foreach (q[i]) if (q[i] == lr) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int m_sel(input int s, input int t, input int d);
    return s == 0 ? t : s == 1 ? d : s == 2 ? 29 : 31;
  endfunction
  task automatic check_outs();
    chk("count", 32'(bus.count), q.size());
    chk("dest_out", 32'(bus.dest_out), q.size() ? q[0] : 0);
    chk("dest_valid", 32'(bus.dest_valid), q.size() != 0);
    chk("full", 32'(bus.full), q.size() == DEPTH);
    chk("empty", 32'(bus.empty), q.size() == 0);
    chk("overflow", 32'(bus.overflow), m_ov);
    chk("underflow", 32'(bus.underflow), m_ud);
  endtask
  task automatic step(input bit p, input bit po, input bit fl, input int s,
                      input int t, input int d, input int lr);
    bit popped, pushed;
    bus.push = p; bus.pop = po; bus.flush = fl; bus.sel = 2'(s);
    bus.rt = 5'(t); bus.rd = 5'(d); bus.lookup_reg = 5'(lr);
    #1;
    chk("lookup_hit", 32'(bus.lookup_hit), m_hit(lr));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      popped = po && q.size() > 0;
      pushed = p && (q.size() < DEPTH || popped);
      if (p && !pushed) m_ov = 1'b1;
      if (po && q.size() == 0 && !p) m_ud = 1'b1;
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(m_sel(s, t, d));
    end
    #1;
    check_outs();
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0;
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2;
    bus.lookup_reg = (q.size() && q[0] != 0) ? 5'(q[0]) : 5'd31;
    reset = 1'b0;
    #1;
    q.delete(); m_ov = 1'b0; m_ud = 1'b0;
    check_outs();
    chk("rst_hit", 32'(bus.lookup_hit), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    bus.push = 0; bus.pop = 0; bus.flush = 0; bus.sel = 0;
    bus.rt = 0; bus.rd = 0; bus.lookup_reg = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    reset = 1'b1;
    // all four selections, then drain in order
    step(1, 0, 0, 0, 5, 0, 0);
    step(1, 0, 0, 1, 0, 12, 5);
    step(1, 0, 0, 2, 0, 0, 12);
    step(1, 0, 0, 3, 0, 0, 29);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 0, 31);
    // overflow, then push+pop while full
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 10 + i, 0, 0);
    step(1, 0, 0, 0, 20, 0, 20);
    step(1, 1, 0, 1, 0, 21, 21);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 21);
    // empty: pop then push+pop
    step(0, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 7, 0, 7);
    step(0, 1, 0, 0, 0, 0, 7);
    // lookup with index 0 in the queue
    step(1, 0, 0, 1, 0, 8, 8);
    step(1, 0, 0, 1, 0, 0, 8);
    step(0, 0, 0, 0, 0, 0, 8);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 8);
    step(0, 0, 0, 0, 0, 0, 8);
    step(0, 1, 0, 0, 0, 0, 0);
    // pointer wrap with interleaved pops
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 1 + i, 0, 1 + i);
      if (i % 2 == 1) step(0, 1, 0, 0, 0, 0, i);
    end
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 4 + i);
    async_reset();
    // flush beats a same-cycle push
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 3 + i, 0, 0);
    step(1, 0, 1, 0, 9, 0, 4);
    step(0, 0, 0, 0, 0, 0, 4);
    for (int n = 0; n < 600; n++) begin
      int lr;
      lr = (q.size() && $urandom_range(0, 1)) ? q[$urandom_range(0, q.size() - 1)]
                                              : int'($urandom_range(0, 31));
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
           $urandom_range(0, 39) == 0, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), lr);
      if (n == 300) async_reset();
    end
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 17 + i, 0, 17);
    async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_dest_queue.md
# wb_dest_queue

Parametrised successor to the register-file write-address selector. Selects the write-back destination register (rt, rd, stack pointer or return address) and queues it for long-latency operations (mult/div, memory loads), so the destination is held until the result retires. A lookup port reports whether a source register has a pending write, which the control unit uses for stall decisions. Sits between instruction decode and the register file's write-address input.

## Interface
- REG_W, 5, register index width
- DEPTH, 4, queue entries; power of two, at least 2
- SP_IDX, 29, index written when sel = 2'b10
- RA_IDX, 31, index written when sel = 2'b11
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- rt  in  REG_W  instruction field [20:16]
- rd  in  REG_W  instruction field [15:11]
- sel  in  2  destination select: 00 rt, 01 rd, 10 SP_IDX, 11 RA_IDX
- push  in  1  enqueue the selected destination
- pop  in  1  retire the head entry
- flush  in  1  synchronous clear of all queued entries
- lookup_reg  in  REG_W  register to test for a pending write
- lookup_hit  out  1  combinational; high when any valid entry equals lookup_reg and lookup_reg != 0
- dest_out  out  REG_W  head entry index; 0 when empty
- dest_valid  out  1  queue non-empty
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  clog2(DEPTH+1)  number of valid entries
- overflow  out  1  sticky; set on push while full with no pop
- underflow  out  1  sticky; set on pop while empty

## Operation
- Selection is combinational: 00 → rt, 01 → rd, 10 → SP_IDX, 11 → RA_IDX. Constants are truncated to REG_W.
- The queue is a circular buffer with DEPTH entries, a write pointer, a read pointer and a count. Pointers wrap modulo DEPTH.
- Per-cycle priority is flush, then push and pop:
  - flush: pointers and count go to 0 and all entry valids are cleared. A push or pop in the same cycle is dropped, and overflow/underflow are not set.
  - push only, not full: write the selected index at the write pointer, increment the write pointer, count +1.
  - push only, full: dropped, overflow ← 1.
  - pop only, non-empty: increment the read pointer and clear the head's valid, count −1.
  - pop only, empty: ignored, underflow ← 1.
  - push and pop, non-empty (including full): both are performed and count is unchanged. The new entry goes at the old write pointer.
  - push and pop, empty: the pop is ignored without setting underflow, and the push proceeds (count → 1).
- Index 0 is enqueued normally but never produces a lookup hit.
- lookup_hit ORs the comparisons over valid entries only. An entry retired in cycle k no longer hits after edge k.
- overflow and underflow are cleared only by reset.
- Reset values: count 0, pointers 0, all valids 0, dest_out 0, dest_valid 0, empty 1, full 0, overflow 0, underflow 0, lookup_hit 0.

## Timing
- Selection has zero-cycle (combinational) delay. Queue outputs are registered state.
- A push sampled at edge k is visible on dest_out/dest_valid/count immediately after edge k, i.e. one-cycle latency.
- A pop at edge k presents the next entry, or 0 with dest_valid low, after edge k.
- lookup_hit is combinational from lookup_reg and the current entries. It does not see a same-cycle push until after the edge.
- Reset asserted mid-operation clears all state asynchronously, without waiting for clk. Deassertion is assumed synchronous to clk upstream.
- flush takes effect at the next edge, and the outputs reflect the empty state after that edge.

## Test plan
- Reset, then push with sel=00/rt=5, sel=01/rd=12, sel=10, sel=11 on consecutive edges → count 4, full 1; pops then yield dest_out 5, 12, 29, 31, after which dest_out=0, empty=1.
- Fill DEPTH=4, push again → entry dropped, overflow=1, count 4; push+pop while full → count stays 4, and the new entry appears last after three further pops.
- Pop while empty → underflow=1, count 0; push+pop while empty → count 1, underflow unchanged.
- Enqueue rd=8 and rd=0, set lookup_reg=8 → hit=1; lookup_reg=0 → hit=0; after popping the 8 entry, lookup_reg=8 → hit=0.
- Push 6 entries with interleaved pops to exercise pointer wrap → FIFO order is preserved across the wrap.
- With 3 entries queued, assert flush together with push → count 0, no overflow. Then pull reset low between edges → all outputs go to reset values immediately.
